// File: rtl/find_first_one.sv
// Two-stage pipelined priority encoder: reports the lowest set bit index of each sampled word.
// Define FFO_MSB_FIRST_EN to report the highest set bit index instead.
module find_first_one #(
  parameter  int unsigned N  = 64,
  localparam int unsigned OW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [N:0]    data,
  output logic [OW-1:0] out,
  output logic          valid
);

  // Leaf count rounded up to a power of two; extra leaves are permanently invalid.
  localparam int unsigned P = 1 << OW;

  logic [N:0]    r_d;
  logic [OW-1:0] r_out;
  logic          r_valid;
  logic          w_root_v;
  logic [OW-1:0] w_root_idx;

  // Each level halves the node count; level OW holds the single root pair.
  for (genvar l = 0; l <= int'(OW); l++) begin : g_lvl
    localparam int unsigned M = P >> l;
    logic [M-1:0]  w_v;
    logic [OW-1:0] w_idx [M];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < int'(P); i++) begin : g_bit
        if (i <= int'(N)) begin : g_real
          assign w_v[i]   = r_d[i];
          assign w_idx[i] = OW'(i);
        end else begin : g_pad
          assign w_v[i]   = 1'b0;
          assign w_idx[i] = '0;
        end
      end
    end else begin : g_merge
      for (genvar j = 0; j < int'(M); j++) begin : g_node
        assign w_v[j] = g_lvl[l-1].w_v[2*j] | g_lvl[l-1].w_v[2*j+1];
`ifdef FFO_MSB_FIRST_EN
        assign w_idx[j] = g_lvl[l-1].w_v[2*j+1] ? g_lvl[l-1].w_idx[2*j+1]
                                                : g_lvl[l-1].w_idx[2*j];
`else
        assign w_idx[j] = g_lvl[l-1].w_v[2*j] ? g_lvl[l-1].w_idx[2*j]
                                              : g_lvl[l-1].w_idx[2*j+1];
`endif
      end
    end
  end

  assign w_root_v   = g_lvl[OW].w_v[0];
  assign w_root_idx = g_lvl[OW].w_idx[0];

  // Stage 1 samples the word, stage 2 registers the scan; index forced to 0 on an empty word.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_d     <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_d     <= data;
      r_out   <= w_root_v ? w_root_idx : '0;
      r_valid <= w_root_v;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

endmodule

// File: tb/tb_find_first_one.sv
// Scoreboard bench for find_first_one: tagged expected results checked by an independent monitor.
module tb_find_first_one;

  localparam int unsigned N  = 64;
  localparam int unsigned OW = 7;

  logic          clk = 1'b0;
  logic          rstb;
  logic [N:0]    data;
  logic [OW-1:0] out;
  logic          valid;

  logic [1:0]  d1;
  logic [7:0]  d7;
  logic [31:0] d31;
  logic [0:0]  o1;
  logic [2:0]  o7;
  logic [4:0]  o31;
  logic        v1, v7, v31;

  typedef struct {
    int         due;
    logic       v;
    logic [6:0] idx;
  } exp_t;

  exp_t q[$];
  int   edge_cnt;
  int   n_tests;
  int   n_fail;

  always #5 clk = ~clk;

  find_first_one #(.N(N)) u_dut (.clk(clk), .rstb(rstb), .data(data), .out(out), .valid(valid));
  find_first_one #(.N(1)) u_n1 (.clk(clk), .rstb(rstb), .data(d1), .out(o1), .valid(v1));
  find_first_one #(.N(7)) u_n7 (.clk(clk), .rstb(rstb), .data(d7), .out(o7), .valid(v7));
  find_first_one #(.N(31)) u_n31 (.clk(clk), .rstb(rstb), .data(d31), .out(o31), .valid(v31));

  // Edges since reset release; a word presented now is due at edge_cnt + 2.
  always @(posedge clk or posedge rstb) begin
    if (rstb) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  // Reference: scan every bit of the word, keep lowest (or highest) set index.
  function automatic logic [7:0] ref_ffo(input logic [64:0] w, input int n);
    logic [7:0] r;
    r = 8'h0;
    for (int i = 0; i <= n; i++) begin
      if (w[i]) begin
`ifdef FFO_MSB_FIRST_EN
        r = {1'b1, 7'(i)};
`else
        if (!r[7]) r = {1'b1, 7'(i)};
`endif
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] a_idx, input logic a_v,
                       input logic [6:0] e_idx, input logic e_v);
    n_tests++;
    if (a_idx !== e_idx || a_v !== e_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got out=%0d valid=%b, want out=%0d valid=%b",
               name, $time, a_idx, a_v, e_idx, e_v);
    end
  endtask

  task automatic push(input logic [64:0] w);
    exp_t       e;
    logic [7:0] r;
    r     = ref_ffo(w, 64);
    e.due = edge_cnt + 2;
    e.v   = r[7];
    e.idx = r[6:0];
    q.push_back(e);
  endtask

  task automatic drive(input logic [64:0] w);
    @(negedge clk);
    data = w;
    push(w);
  endtask

  task automatic release_rst(input logic [64:0] w);
    @(negedge clk);
    rstb = 1'b0;
    data = w;
    push(w);
  endtask

  task automatic sweep(input logic [1:0] w1, input logic [7:0] w7, input logic [31:0] w31,
                       input string name);
    logic [7:0] r;
    @(negedge clk);
    d1  = w1;
    d7  = w7;
    d31 = w31;
    repeat (2) @(negedge clk);
    r = ref_ffo(65'(w1), 1);
    check({name, "_n1"}, 7'(o1), v1, r[6:0], r[7]);
    r = ref_ffo(65'(w7), 7);
    check({name, "_n7"}, 7'(o7), v7, r[6:0], r[7]);
    r = ref_ffo(65'(w31), 31);
    check({name, "_n31"}, 7'(o31), v31, r[6:0], r[7]);
  endtask

  // Monitor: zero outputs in reset and on the first edge after release, else due results.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstb) begin
        check("reset_hold", out, valid, 7'd0, 1'b0);
      end else if (edge_cnt == 1) begin
        check("post_release", out, valid, 7'd0, 1'b0);
      end else begin
        while (q.size() > 0 && q[0].due < edge_cnt) begin
          n_tests++;
          n_fail++;
          $display("FAIL missed_result: due edge %0d, now edge %0d", q[0].due, edge_cnt);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == edge_cnt) begin
          e = q.pop_front();
          check("stream", out, valid, e.idx, e.v);
        end
      end
    end
  end

  initial begin
    logic [95:0] ra, rb, rc;
    rstb = 1'b1;
    data = '0;
    d1   = '0;
    d7   = '0;
    d31  = '0;
    repeat (250) @(negedge clk);

    // Single bits 0..64, one per cycle.
    release_rst(65'(1));
    for (int i = 1; i <= 64; i++) drive(65'(1) << i);

    // Multiple bits and zero words between non-zero ones.
    drive(65'hF0);
    drive((65'(1) << 64) | 65'h8);
    drive('1);
    drive(65'h8);
    drive(65'h0);
    drive(65'h2);

    // Dense random words.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      drive(ra[64:0]);
    end
    // Sparse random words spread across the index range.
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom()};
      rc = {$urandom(), $urandom(), $urandom()};
      ra = (ra & rb & rc) >> $urandom_range(0, 64);
      drive(ra[64:0]);
    end

    // Asynchronous reset in the middle of a non-zero stream.
    drive(65'h10);
    drive(65'h30);
    @(posedge clk);
    #2;
    rstb = 1'b1;
    #1;
    check("async_reset", out, valid, 7'd0, 1'b0);
    q.delete();
    data = 65'h4;
    repeat (3) @(negedge clk);
    release_rst(65'h4000);
    drive(65'h0);
    drive(65'(1) << 64);
    drive(65'h6);

    // Narrower instances: extreme single-bit, all-ones and zero words.
    sweep('1, '1, '1, "ones");
    sweep(2'h1, 8'h01, 32'h1, "lsb");
    sweep(2'h2, 8'h80, 32'h8000_0000, "msb");
    sweep(2'h3, 8'h81, 32'h8000_0001, "msb_lsb");
    sweep(2'h0, 8'h28, 32'h0010_0400, "mid");
    sweep(2'h0, 8'h00, 32'h0, "zero");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    n_tests++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
